stoch_add_mat_sched: RTL and testbench
======================================

// Module: stoch_add_mat_sched
// PURPOSE
//  Round-robin scheduler sharing one stochastic matrix adder array among NUM_REQ requesters.
//  - Grants the array in fixed windows of STREAM_LEN bitstream cycles.
//  - Clears adder state before each window, drives the operand-mux select,
//    flags valid output bits and signals window completion.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  STREAM_LEN  256  bitstream samples per window (>=1)
//  ADD_LAT     1    adder array latency in cycles, operand bit to Y bit (>=0)
// PORTS
//  CLK      in   1                  clock, all logic on rising edge
//  RST      in   1                  synchronous, active-high reset
//  REQ      in   NUM_REQ            per-requester request, level; held until DONE
//  GNT      out  NUM_REQ            one-hot grant; granted requester drives A/B bits
//  SEL      out  $clog2(NUM_REQ)    operand/result mux select = index of GNT bit
//  ADD_CLR  out  1                  sync clear to adder array internal state
//  Y_VALID  out  1                  adder Y bits belong to the granted stream
//  DONE     out  NUM_REQ            one-cycle one-hot pulse, window complete
//  BUSY     out  1                  state != IDLE
//  LEN_CFG  in   $clog2(STREAM_LEN+1)  runtime window length (only with STOCH_SCHED_LEN_CFG_EN)
// BEHAVIOUR
//  - Reset: all outputs 0 at the next edge, from any state; state=IDLE; RR pointer=0.
//    Reset during a window aborts it with no DONE pulse.
//  - States:
//    - IDLE:  no REQ -> stay. Any REQ -> CLEAR; winner latched into GNT/SEL.
//    - CLEAR: 1 cycle. ADD_CLR=1, GNT/SEL held, Y_VALID=0; -> RUN, cnt=0.
//    - RUN:   STREAM_LEN+ADD_LAT cycles, cnt 0..STREAM_LEN+ADD_LAT-1.
//      Y_VALID=1 while cnt>=ADD_LAT, i.e. exactly STREAM_LEN cycles.
//  - Arbitration (IDLE or last RUN cycle): search starts at index last_grant+1,
//    mod NUM_REQ; first REQ bit set wins.
//  - Last RUN cycle: DONE[winner]=1.
//    - REQ bits of other requesters set -> next edge goes to CLEAR with the new winner.
//    - Otherwise -> IDLE; GNT=0 and Y_VALID=0 at that edge.
//    - The finishing requester's own REQ does not count in this search. It is
//      re-granted only if it asserts REQ after DONE and wins a later arbitration.
//  - Early withdraw: granted REQ drops in CLEAR/RUN -> window aborted at the next edge.
//    No DONE; state -> IDLE; RR pointer still advances past it.
//  - Latency: REQ seen in IDLE -> GNT+ADD_CLR on the next edge -> first Y_VALID
//    1+ADD_LAT cycles after ADD_CLR.
//  - Other requesters' REQ changes mid-window: no effect until the last RUN cycle.
//  - Counter width: $clog2(STREAM_LEN+ADD_LAT+1); no wrap inside a window.
//  - GNT is always one-hot or zero; SEL holds its last value while GNT=0.
// CONFIGURATION
//  STOCH_SCHED_LEN_CFG_EN defined:
//    - LEN_CFG port exists; window length is sampled from LEN_CFG on entry to CLEAR.
//    - LEN_CFG=0 is treated as STREAM_LEN. Values above STREAM_LEN saturate to STREAM_LEN.
//  STOCH_SCHED_LEN_CFG_EN undefined: no LEN_CFG port; window length fixed at STREAM_LEN.
// STRUCTURE
//  - Package stoch_sched_pkg holds:
//    - typedef enum logic [1:0] {IDLE, CLEAR, RUN} sched_state_t;
//    - function cnt_width(len, lat) returning the counter width.
//  - Sub-module stoch_rr_arb #(NUM_REQ): combinational masked round-robin pick.
//    - Inputs: req vector, last_grant index.
//    - Outputs: one-hot winner, winner index, any-valid.
//  - This module holds the FSM, window counter, last_grant register and output registers.
//  - Grants drive an external stoch_add_mat operand mux.
// TESTING
//  - Reset: RST=1 for 3 cycles mid-RUN -> next edge all outputs 0, BUSY=0; no DONE.
//  - Single request: REQ=4'b0010 held.
//    - One cycle later GNT=0010, SEL=1, ADD_CLR=1 for 1 cycle.
//    - Y_VALID high for exactly 256 cycles, starting 2 cycles after ADD_CLR.
//    - DONE=0010 pulsed on the last RUN cycle.
//  - Round-robin: REQ=4'b1111 held throughout -> grant order 0,1,2,3,0.
//    - Windows are back-to-back, each separated by exactly one CLEAR cycle.
//  - Withdraw: REQ[2] dropped at RUN cnt=10 -> next edge GNT=0, IDLE, no DONE.
//    - Next arbitration starts its search at index 3.
//  - ADD_LAT=0, STREAM_LEN=1: REQ=4'b0001 -> CLEAR, 1 RUN cycle with Y_VALID=1 and DONE=0001 -> IDLE.
//  - With STOCH_SCHED_LEN_CFG_EN:
//    - LEN_CFG=16 -> Y_VALID high for 16 cycles.
//    - LEN_CFG=0 -> 256 cycles.
//    - LEN_CFG changed mid-window -> current window length unchanged.

Source files
------------

// File: rtl/stoch_sched_pkg.sv
// stoch_sched_pkg: shared state encoding and sizing helper for the stochastic
// matrix adder scheduler.
package stoch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    // Bits needed to count 0..len+lat-1 with headroom so the window counter never wraps
    function automatic int cnt_width(input int len, input int lat);
        return $clog2(len + lat + 1);
    endfunction

endpackage

// File: rtl/stoch_rr_arb.sv
// stoch_rr_arb: combinational masked round-robin pick. Requesters above last_grant
// win first; if none of them request, the lowest requesting index wins.
module stoch_rr_arb
    import stoch_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] upper_mask_s;
    logic [NUM_REQ-1:0] masked_s;
    logic [NUM_REQ-1:0] pick_s;

    // Mask off indices at or below last_grant, then isolate the lowest set bit
    always_comb begin
        upper_mask_s = NUM_REQ'(0);
        gnt_idx      = IDX_W'(0);
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask_s[i] = (i > int'(last_grant));
        end
        masked_s = req & upper_mask_s;
        pick_s   = (masked_s != NUM_REQ'(0)) ? masked_s : req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            gnt_idx = pick_s[i] ? IDX_W'(i) : gnt_idx;
        end
        gnt_onehot = pick_s & (~pick_s + NUM_REQ'(1));
        any_valid  = (req != NUM_REQ'(0));
    end

endmodule

// File: rtl/stoch_add_mat_sched.sv
// stoch_add_mat_sched: round-robin scheduler sharing one stochastic matrix adder array
// in fixed bitstream windows. Define STOCH_SCHED_LEN_CFG_EN for a runtime LEN_CFG port.
module stoch_add_mat_sched
    import stoch_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STREAM_LEN = 256,
    parameter int ADD_LAT    = 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              REQ,
    output logic [NUM_REQ-1:0]              GNT,
    output logic [$clog2(NUM_REQ)-1:0]      SEL,
    output logic                            ADD_CLR,
    output logic                            Y_VALID,
    output logic [NUM_REQ-1:0]              DONE,
    output logic                            BUSY
`ifdef STOCH_SCHED_LEN_CFG_EN
    ,
    input  logic [$clog2(STREAM_LEN+1)-1:0] LEN_CFG
`endif
);

    localparam int                IDX_W   = $clog2(NUM_REQ);
    localparam int                LEN_W   = $clog2(STREAM_LEN + 1);
    localparam int                CNT_W   = cnt_width(STREAM_LEN, ADD_LAT);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_REQ - 1);

    sched_state_t       state_r;
    sched_state_t       state_nxt_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CNT_W-1:0]   last_cnt_s;
    logic [LEN_W-1:0]   win_len_r;
    logic [LEN_W-1:0]   win_len_nxt_s;
    logic [LEN_W-1:0]   cfg_len_s;

    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   rr_ptr_nxt_s;
    logic [IDX_W-1:0]   last_grant_s;
    logic [IDX_W-1:0]   sel_r;
    logic [IDX_W-1:0]   sel_nxt_s;

    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] gnt_nxt_s;
    logic [NUM_REQ-1:0] done_r;
    logic [NUM_REQ-1:0] done_nxt_s;
    logic [NUM_REQ-1:0] arb_req_s;
    logic [NUM_REQ-1:0] arb_onehot_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_any_s;

    logic               add_clr_r;
    logic               add_clr_nxt_s;
    logic               y_valid_r;
    logic               y_valid_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;

    logic               cnt_last_s;
    logic               own_req_s;
    logic               grant_s;

`ifdef STOCH_SCHED_LEN_CFG_EN
    // Zero and oversize requests both mean a full-length window
    always_comb begin
        if ((LEN_CFG == LEN_W'(0)) || (LEN_CFG > LEN_W'(STREAM_LEN))) begin
            cfg_len_s = LEN_W'(STREAM_LEN);
        end else begin
            cfg_len_s = LEN_CFG;
        end
    end
`else
    assign cfg_len_s = LEN_W'(STREAM_LEN);
`endif

    // rr_ptr_r is the next search start, so the arbiter sees the index just before it
    assign last_grant_s = (rr_ptr_r == IDX_W'(0)) ? IDX_MAX : (rr_ptr_r - IDX_W'(1));
    // The finishing requester is excluded from the end-of-window search
    assign arb_req_s    = (state_r == RUN) ? (REQ & ~gnt_r) : REQ;
    assign own_req_s    = REQ[sel_r];
    assign last_cnt_s   = CNT_W'(win_len_r) + CNT_W'(ADD_LAT) - CNT_W'(1);
    assign cnt_last_s   = (cnt_r == last_cnt_s);
    assign grant_s      = (state_nxt_s == CLEAR);

    stoch_rr_arb #(
        .NUM_REQ    (NUM_REQ)
    ) arb_u (
        .req        (arb_req_s),
        .last_grant (last_grant_s),
        .gnt_onehot (arb_onehot_s),
        .gnt_idx    (arb_idx_s),
        .any_valid  (arb_any_s)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: grant, clear, run; a withdrawn grant aborts before the last cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (!own_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (cnt_last_s) begin
                    if (arb_any_s) begin
                        state_nxt_s = CLEAR;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!own_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, counter, pointer and window length
    always_comb begin
        cnt_nxt_s     = CNT_W'(0);
        gnt_nxt_s     = NUM_REQ'(0);
        sel_nxt_s     = sel_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        win_len_nxt_s = win_len_r;
        if (grant_s) begin
            gnt_nxt_s     = arb_onehot_s;
            sel_nxt_s     = arb_idx_s;
            rr_ptr_nxt_s  = (arb_idx_s == IDX_MAX) ? IDX_W'(0) : (arb_idx_s + IDX_W'(1));
            win_len_nxt_s = cfg_len_s;
        end else if (state_nxt_s == RUN) begin
            gnt_nxt_s = gnt_r;
            cnt_nxt_s = (state_r == RUN) ? (cnt_r + CNT_W'(1)) : CNT_W'(0);
        end else begin
            gnt_nxt_s = NUM_REQ'(0);
        end
        add_clr_nxt_s = grant_s;
        y_valid_nxt_s = (state_nxt_s == RUN) && (int'(cnt_nxt_s) >= ADD_LAT);
        if ((state_nxt_s == RUN) && (cnt_nxt_s == last_cnt_s)) begin
            done_nxt_s = gnt_nxt_s;
        end else begin
            done_nxt_s = NUM_REQ'(0);
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output, counter and arbitration registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r     <= CNT_W'(0);
            win_len_r <= LEN_W'(STREAM_LEN);
            rr_ptr_r  <= IDX_W'(0);
            sel_r     <= IDX_W'(0);
            gnt_r     <= NUM_REQ'(0);
            done_r    <= NUM_REQ'(0);
            add_clr_r <= 1'b0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            win_len_r <= win_len_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            sel_r     <= sel_nxt_s;
            gnt_r     <= gnt_nxt_s;
            done_r    <= done_nxt_s;
            add_clr_r <= add_clr_nxt_s;
            y_valid_r <= y_valid_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign GNT     = gnt_r;
    assign SEL     = sel_r;
    assign ADD_CLR = add_clr_r;
    assign Y_VALID = y_valid_r;
    assign DONE    = done_r;
    assign BUSY    = busy_r;

endmodule

// File: tb/tb_stoch_add_mat_sched.sv
// tb_stoch_add_mat_sched: scoreboard bench; each expected window is queued when its
// request is driven and compared when the monitor sees the window close.
module tb_stoch_add_mat_sched;

    typedef struct {
        int gnt;
        int sel;
        int len;
        int done;
        int lat;
        int span;
        bit chk_len;
        bit chk_span;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       add_clr;
    logic       y_valid;
    logic [3:0] done;
    logic       busy;

    logic [3:0] req_s;
    logic [3:0] gnt_s;
    logic [1:0] sel_s;
    logic       add_clr_s;
    logic       y_valid_s;
    logic [3:0] done_s;
    logic       busy_s;
`ifdef STOCH_SCHED_LEN_CFG_EN
    logic [8:0] len_cfg;
    logic       len_cfg_s;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    win_t exp_q[$];

    bit   active = 1'b0;
    int   m_gnt;
    int   m_sel;
    int   m_len;
    int   m_lat;
    int   m_done;
    int   m_age;

    always #5 clk = ~clk;

    stoch_add_mat_sched #(.NUM_REQ(4), .STREAM_LEN(256), .ADD_LAT(1)) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .GNT     (gnt),
        .SEL     (sel),
        .ADD_CLR (add_clr),
        .Y_VALID (y_valid),
        .DONE    (done),
        .BUSY    (busy)
`ifdef STOCH_SCHED_LEN_CFG_EN
        ,
        .LEN_CFG (len_cfg)
`endif
    );

    stoch_add_mat_sched #(.NUM_REQ(4), .STREAM_LEN(1), .ADD_LAT(0)) dut_small (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req_s),
        .GNT     (gnt_s),
        .SEL     (sel_s),
        .ADD_CLR (add_clr_s),
        .Y_VALID (y_valid_s),
        .DONE    (done_s),
        .BUSY    (busy_s)
`ifdef STOCH_SCHED_LEN_CFG_EN
        ,
        .LEN_CFG (len_cfg_s)
`endif
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_win(input int g, input int s, input int len, input int d,
                            input int lat, input int span, input bit cl, input bit cs);
        win_t w;
        w.gnt = g; w.sel = s; w.len = len; w.done = d;
        w.lat = lat; w.span = span; w.chk_len = cl; w.chk_span = cs;
        exp_q.push_back(w);
    endtask

    task automatic wait_done(input int who);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((done == 4'b0000) && (n < 1000));
        check_eq("done_wait", int'(done), who);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_gnt"},     int'(gnt),     0);
        check_eq({tag, "_add_clr"}, int'(add_clr), 0);
        check_eq({tag, "_y_valid"}, int'(y_valid), 0);
        check_eq({tag, "_done"},    int'(done),    0);
        check_eq({tag, "_busy"},    int'(busy),    0);
    endtask

    // Window monitor: measures each grant window and retires it against the scoreboard
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (active && ((add_clr == 1'b1) || (gnt == 4'b0000))) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_win", m_gnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("win_gnt",  m_gnt,  e.gnt);
                    check_eq("win_sel",  m_sel,  e.sel);
                    check_eq("win_done", m_done, e.done);
                    check_eq("win_lat",  m_lat,  e.lat);
                    if (e.chk_len)  check_eq("win_len",  m_len,     e.len);
                    if (e.chk_span) check_eq("win_span", m_age + 1, e.span);
                end
                active = 1'b0;
            end
            if (add_clr == 1'b1) begin
                active = 1'b1;
                m_gnt  = int'(gnt);
                m_sel  = int'(sel);
                m_len  = 0;
                m_lat  = -1;
                m_done = 0;
                m_age  = 0;
            end else if (active) begin
                m_age++;
                if (y_valid == 1'b1) begin
                    m_len++;
                    if (m_lat < 0) m_lat = m_age;
                end
                m_done = m_done | int'(done);
            end else if ((y_valid == 1'b1) || (done != 4'b0000)) begin
                check_eq("stray_out", int'({y_valid, done}), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        req_s = 4'b0000;
`ifdef STOCH_SCHED_LEN_CFG_EN
        len_cfg   = 9'd0;
        len_cfg_s = 1'b0;
`endif
        cycles(3);
        check_idle_outputs("rst");
        check_eq("rst_sel", int'(sel), 0);
        check_eq("rst_small_busy", int'(busy_s), 0);
        rst = 1'b0;
        cycles(1);

        // single requester, full window
        push_win(2, 1, 256, 2, 2, 258, 1'b1, 1'b1);
        req = 4'b0010;
        cycles(1);
        check_eq("single_gnt", int'(gnt), 2);
        check_eq("single_sel", int'(sel), 1);
        check_eq("single_clr", int'(add_clr), 1);
        check_eq("single_busy", int'(busy), 1);
        cycles(1);
        check_eq("single_clr_off", int'(add_clr), 0);
        check_eq("single_yv_early", int'(y_valid), 0);
        cycles(1);
        check_eq("single_yv_on", int'(y_valid), 1);
        wait_done(2);
        req = 4'b0000;
        cycles(1);
        check_idle_outputs("single_end");
        check_eq("single_sel_hold", int'(sel), 1);

        // round robin from a fresh pointer
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_win(1 << (k % 4), k % 4, 256, 1 << (k % 4), 2, 258, 1'b1, 1'b1);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(1 << (k % 4));
        end
        req = 4'b0000;
        cycles(2);

        // reset in the middle of a run window
        push_win(1, 0, 0, 0, 2, 0, 1'b0, 1'b0);
        req = 4'b0001;
        cycles(50);
        rst = 1'b1;
        req = 4'b0000;
        cycles(1);
        check_idle_outputs("midrst");
        cycles(2);
        rst = 1'b0;
        cycles(2);
        check_eq("midrst_busy_after", int'(busy), 0);

        // withdraw at cnt=10, then search resumes at index 3
        push_win(4, 2, 10, 0, 2, 12, 1'b1, 1'b1);
        push_win(8, 3, 256, 8, 2, 258, 1'b1, 1'b1);
        req = 4'b0100;
        cycles(1);
        check_eq("wd_gnt", int'(gnt), 4);
        cycles(11);
        req = 4'b1011;
        cycles(1);
        check_idle_outputs("wd_abort");
        wait_done(8);
        req = 4'b0000;
        cycles(3);

        // STREAM_LEN=1, ADD_LAT=0 instance
        req_s = 4'b0001;
        cycles(1);
        check_eq("small_gnt", int'(gnt_s), 1);
        check_eq("small_sel", int'(sel_s), 0);
        check_eq("small_clr", int'(add_clr_s), 1);
        check_eq("small_yv_clr", int'(y_valid_s), 0);
        cycles(1);
        check_eq("small_yv", int'(y_valid_s), 1);
        check_eq("small_done", int'(done_s), 1);
        check_eq("small_clr_off", int'(add_clr_s), 0);
        req_s = 4'b0000;
        cycles(1);
        check_eq("small_end_gnt", int'(gnt_s), 0);
        check_eq("small_end_busy", int'(busy_s), 0);
        check_eq("small_end_yv", int'(y_valid_s), 0);
        check_eq("small_end_done", int'(done_s), 0);

`ifdef STOCH_SCHED_LEN_CFG_EN
        // runtime length: 16, changed mid-window, then zero and oversize
        push_win(1, 0, 16, 1, 2, 18, 1'b1, 1'b1);
        len_cfg = 9'd16;
        req = 4'b0001;
        cycles(5);
        len_cfg = 9'd100;
        wait_done(1);
        req = 4'b0000;
        cycles(3);
        push_win(1, 0, 256, 1, 2, 258, 1'b1, 1'b1);
        len_cfg = 9'd0;
        req = 4'b0001;
        wait_done(1);
        req = 4'b0000;
        cycles(3);
        push_win(1, 0, 256, 1, 2, 258, 1'b1, 1'b1);
        len_cfg = 9'd300;
        req = 4'b0001;
        wait_done(1);
        req = 4'b0000;
        cycles(3);
`endif

        cycles(3);
        check_eq("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
